// File: rtl/h80_uart_tx.sv
// h80_uart_tx: byte-wide transmit FIFO feeding an 8N1 UART serializer.
// Bytes written over the I/O bus queue in a small FIFO; the serializer pops
// them one at a time and shifts them out LSB first with start and stop bits.
//
// Write handshake: wr_en is a one-cycle valid strobe carrying wr_data; the
// inverse of the registered full flag acts as ready. A strobe seen while full
// is not stored and instead sets the sticky overrun flag until reset.
module h80_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overrun,
    output logic       txd,
    output logic [1:0] dbg_state
);

    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    // Serializer registers and their next values
    state_t               state;
    state_t               state_next;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt_next;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_idx_next;
    logic [7:0]           shift_reg;
    logic [7:0]           shift_next;
    logic                 txd_next;
    logic                 bit_end;

    // A write is taken only when the registered full flag is clear; a pop in
    // the same cycle does not make room for it.
    assign push      = wr_en && !full;
    assign bit_end   = (bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));
    assign dbg_state = state;

    // Occupancy after this edge: push and pop together cancel out.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Store accepted bytes at the tail; storage needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, count, registered status flags and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            overrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(FIFO_DEPTH));
            empty <= (count_next == '0);
            if (wr_en && full) begin
                overrun <= 1'b1;
            end
        end
    end

    // Serializer next-state logic: bit timing, shifting and FIFO pops.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        txd_next     = txd;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                txd_next     = 1'b1;
                bit_cnt_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = ST_START;
                    txd_next   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    bit_idx_next = 3'd0;
                    txd_next     = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    state_next   = ST_DATA;
                end else begin
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        txd_next   = 1'b1;
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        txd_next     = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    bit_cnt_next = '0;
                    if (!empty) begin
                        // Back-to-back frame: start bit follows stop directly.
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = ST_START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        txd_next   = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
                end
            end
            default: begin
                state_next   = ST_IDLE;
                bit_cnt_next = '0;
                txd_next     = 1'b1;
            end
        endcase
    end

    // Serializer state register; txd and busy are registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            txd       <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            txd       <= txd_next;
            busy      <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_h80_uart_tx.sv
// Testbench for h80_uart_tx: directed scenarios plus randomized traffic,
// checked every cycle against a frame-timeline reference model and a line
// receiver whose decoded bytes are scoreboarded against the popped bytes.
module tb_h80_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    // Clock and DUT signals
    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overrun;
    logic       txd;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    h80_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overrun  (overrun),
        .txd      (txd),
        .dbg_state(dbg_state)
    );

    // Counters and scoreboard
    int         tests_run    = 0;
    int         tests_failed = 0;
    int         cyc          = 0;
    int         busy_cnt     = 0;
    logic [7:0] exp_q[$];

    // Reference model: pending bytes plus the timeline of the current frame
    logic [7:0] m_q[$];
    bit         m_in_frame = 1'b0;
    int         m_t0       = 0;
    logic [7:0] m_byte     = 8'h00;
    bit         m_ovr      = 1'b0;

    // Line receiver state
    bit         rx_active = 1'b0;
    int         rx_off    = 0;
    logic [7:0] rx_byte   = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected line level from the position within the current frame.
    function automatic logic model_txd();
        int off;
        int b;
        if (!m_in_frame) return 1'b1;
        off = cyc - m_t0;
        b   = off / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    // Advance the model by one clock edge with the inputs sampled there.
    task automatic model_update(input logic r, input logic we, input logic [7:0] d);
        int pre;
        bit start;
        if (r) begin
            m_q.delete();
            exp_q.delete();
            m_in_frame = 1'b0;
            m_ovr      = 1'b0;
            rx_active  = 1'b0;
        end else begin
            pre   = m_q.size();
            start = 1'b0;
            if (!m_in_frame && pre > 0) begin
                start = 1'b1;
            end else if (m_in_frame && (cyc - m_t0) == FRAME) begin
                if (pre > 0) start = 1'b1;
                else m_in_frame = 1'b0;
            end
            if (start) begin
                m_byte     = m_q.pop_front();
                m_t0       = cyc;
                m_in_frame = 1'b1;
                exp_q.push_back(m_byte);
            end
            if (we) begin
                if (pre == DEPTH) m_ovr = 1'b1;
                else m_q.push_back(d);
            end
        end
    endtask

    // Decode frames off txd, sampling mid-bit, and scoreboard the bytes.
    task automatic rx_monitor();
        if (!rx_active) begin
            if (txd == 1'b0) begin
                rx_active = 1'b1;
                rx_off    = 0;
            end
        end else begin
            rx_off++;
            for (int i = 0; i < 8; i++) begin
                if (rx_off == CPB * (i + 1) + CPB / 2) rx_byte[i] = txd;
            end
            if (rx_off == 9 * CPB + CPB / 2) begin
                check("rx_stop", txd, 1'b1);
                if (exp_q.size() == 0) check("rx_unexpected", 1, 0);
                else check("rx_byte", rx_byte, exp_q.pop_front());
                rx_active = 1'b0;
            end
        end
    endtask

    // Driver: one clock cycle with given inputs, then compare to the model.
    task automatic step(input logic r, input logic we, input logic [7:0] d);
        @(negedge clk);
        reset   = r;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        cyc++;
        model_update(r, we, d);
        #1;
        if (busy === 1'b1) busy_cnt++;
        check("txd", txd, model_txd());
        check("flags", {busy, empty, full, overrun},
              {m_in_frame, (m_q.size() == 0), (m_q.size() == DEPTH), m_ovr});
        rx_monitor();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    // Run idle cycles until the model has nothing left to send.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_in_frame || m_q.size() != 0) && n < budget) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        if (n >= budget) check("drain_timeout", 0, 1);
        idle(2);
        check("rx_drain", exp_q.size(), 0);
    endtask

    // Idle until the current frame reaches the given offset.
    task automatic wait_offset(input int off, input int budget);
        int n;
        n = 0;
        while (!(m_in_frame && (cyc - m_t0) == off) && n < budget) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        if (n >= budget) check("wait_timeout", 0, 1);
    endtask

    initial begin
        int dens;
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset state
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hAA);
        check("reset_state", {txd, busy, empty, full, overrun}, 5'b10100);

        // Single 0x55 frame: 40 busy cycles, then idle and empty
        busy_cnt = 0;
        step(1'b0, 1'b1, 8'h55);
        idle(45);
        check("busy_len_single", busy_cnt, FRAME);
        check("idle_after_single", {busy, empty, txd}, 3'b011);

        // Six consecutive writes into a depth-4 FIFO: last one dropped
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h41 + 8'(i));
        check("overrun_six", overrun, 1'b1);
        drain(400);
        check("overrun_sticky", overrun, 1'b1);

        // Back-to-back 0x00 and 0xFF: busy continuously for two frames
        step(1'b1, 1'b0, 8'h00);
        busy_cnt = 0;
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'hFF);
        drain(200);
        check("busy_len_b2b", busy_cnt, 2 * FRAME);

        // Reset during data bit 3 of 0xA5 with two bytes still queued
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        wait_offset(4 * CPB + 1, 100);
        step(1'b1, 1'b1, 8'h77);
        check("reset_midframe", {txd, busy, empty, overrun}, 4'b1010);
        busy_cnt = 0;
        idle(3 * FRAME);
        check("no_frames_after_reset", busy_cnt, 0);

        // Write while full on the same edge as the stop-end pop
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h20);
        step(1'b0, 1'b1, 8'h30);
        step(1'b0, 1'b1, 8'h40);
        step(1'b0, 1'b1, 8'h50);
        check("full_before_pop", full, 1'b1);
        wait_offset(FRAME - 1, 100);
        step(1'b0, 1'b1, 8'h99);
        check("overrun_at_pop", overrun, 1'b1);
        check("full_after_pop", full, 1'b0);
        drain(400);

        // Randomized traffic with varying write density and rare resets
        step(1'b1, 1'b0, 8'h00);
        dens = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) dens = $urandom_range(0, 60);
            step(($urandom_range(0, 599) == 0),
                 ($urandom_range(0, 99) < dens),
                 8'($urandom_range(0, 255)));
        end
        drain(600);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/h80_uart_tx.md
H80_UART_TX -- requirements
Module: h80_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clk cycles per serial bit (integer >= 2).
REQ-002 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, >= 2).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  one-cycle write strobe from the I/O bus slave (byte write to address 0x0000).
REQ-006 wr_data  input  8  byte to transmit, valid with wr_en.
REQ-007 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-008 empty  output  1  FIFO holds zero entries.
REQ-009 busy  output  1  serializer not in IDLE.
REQ-010 overrun  output  1  sticky flag: a write was dropped.
REQ-011 txd  output  1  UART serial line, 8N1, idle high (drives uart_txp).

Function
REQ-012 All outputs SHALL be registered; full, empty, busy derive from registered count/state.
REQ-013 A write SHALL be accepted when wr_en=1 and full=0 at the sampling edge; the byte is stored at the FIFO tail.
REQ-014 A write with wr_en=1 and full=1 SHALL be dropped and set overrun=1, even if a pop occurs in the same cycle.
REQ-015 Simultaneous accepted write and pop SHALL leave the count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-016 Serializer states SHALL be IDLE, START, DATA, STOP.
REQ-017 IDLE: txd=1; if empty=0, pop head into shift register, go to START, drive txd=0 from the same edge.
REQ-018 A byte written to an empty FIFO at edge N SHALL be popped at edge N+1 (txd low after N+1).
REQ-019 Each bit (start, 8 data, stop) SHALL last exactly CLKS_PER_BIT cycles, timed by a bit counter counting 0..CLKS_PER_BIT-1.
REQ-020 START -> DATA after one bit time; DATA sends bits LSB first; DATA -> STOP after bit 7; STOP drives txd=1.
REQ-021 At end of STOP: if empty=0, pop and go directly to START (no idle cycle); otherwise go to IDLE.
REQ-022 One frame SHALL occupy exactly 10*CLKS_PER_BIT cycles; busy=1 for the whole frame.
REQ-023 wr_data SHALL be ignored when wr_en=0; writes are accepted in every serializer state.

Reset
REQ-024 reset=1 at an edge SHALL force: state IDLE, txd=1, busy=0, FIFO pointers/count 0, empty=1, full=0, overrun=0, bit counter 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately (txd=1 after that edge) and discard all queued bytes; writes during reset are ignored.
REQ-026 overrun SHALL be cleared only by reset.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 Single 0x55 written at edge N -> txd low for cycles N+1..N+4, then 1,0,1,0,1,0,1,0 (4 cycles each), stop high 4 cycles; busy=0 and empty=1 after edge N+41.
REQ-028 Six writes 0x41..0x46 on consecutive edges -> 0x41..0x45 accepted, full=1 after fifth write, 0x46 dropped, overrun=1; frames 0x41..0x45 emitted in order.
REQ-029 Two bytes 0x00, 0xFF queued -> second start bit follows first stop bit with no idle cycle; busy continuously high 80 cycles; line shows 0x00 all-low data, 0xFF all-high data.
REQ-030 Reset asserted during data bit 3 of 0xA5 with two bytes queued -> txd=1, busy=0, empty=1, overrun=0 after that edge; txd stays high afterwards, no further frames.
REQ-031 Write while full coincident with STOP-end pop -> write dropped, overrun=1, count goes 4->3.
